// File: rtl/dram_cmd_checker.sv
// dram_cmd_checker
// Protocol checker for a DRAM command stream. It keeps a shadow open-row
// table per bank, a table of logged requests indexed by request ID, and
// per-bank ACT/PRE timers. Illegal ACT/PRE/RD sequences and tRCD/tRP/tRAS
// violations produce a registered one-cycle error pulse and sticky flags.
// The checker also keeps saturating ACT/PRE/RD counts.
// The command encodings are parameters. Set them to match the scheduler's
// CMD_* definitions. Any other command type is ignored.
module dram_cmd_checker #(
    parameter int         NUM_BANKS    = 16,
    parameter int         BG_WIDTH     = 2,
    parameter int         BANK_WIDTH   = 2,
    parameter int         ROW_WIDTH    = 16,
    parameter int         REQ_ID_WIDTH = 6,
    parameter int         CNT_WIDTH    = 16,
    parameter int         T_RCD        = 4,
    parameter int         T_RP         = 4,
    parameter int         T_RAS        = 8,
    parameter logic [2:0] CMD_ACT      = 3'd1,
    parameter logic [2:0] CMD_RD       = 3'd2,
    parameter logic [2:0] CMD_PRE      = 3'd4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           log_valid,
    input  logic [REQ_ID_WIDTH-1:0]        log_id,
    input  logic [BG_WIDTH-1:0]            log_bg,
    input  logic [BANK_WIDTH-1:0]          log_bank,
    input  logic [ROW_WIDTH-1:0]           log_row,
    input  logic [2:0]                     cmd_type,
    input  logic [BG_WIDTH-1:0]            cmd_bg,
    input  logic [BANK_WIDTH-1:0]          cmd_bank,
    input  logic [ROW_WIDTH-1:0]           cmd_row,
    input  logic [REQ_ID_WIDTH-1:0]        cmd_req_id,
    output logic                           err_valid,
    output logic [2:0]                     err_code,
    output logic [BG_WIDTH+BANK_WIDTH-1:0] err_bank,
    output logic [6:0]                     err_flags,
    output logic [NUM_BANKS-1:0]           open_mask,
    output logic [CNT_WIDTH-1:0]           act_count,
    output logic [CNT_WIDTH-1:0]           pre_count,
    output logic [CNT_WIDTH-1:0]           rd_count
);

    localparam int BANK_IDX_W = BG_WIDTH + BANK_WIDTH;
    localparam int LOG_DEPTH  = 1 << REQ_ID_WIDTH;

    // The ACT timer serves both tRCD and tRAS, so it saturates at the larger of the two.
    localparam int ACT_MAX = (T_RCD > T_RAS) ? T_RCD : T_RAS;
    localparam int ACT_TW  = $clog2(ACT_MAX) + 1;
    localparam int PRE_TW  = $clog2(T_RP) + 1;

    localparam logic [ACT_TW-1:0]    ACT_SAT   = ACT_TW'(ACT_MAX);
    localparam logic [ACT_TW-1:0]    ACT_ONE   = ACT_TW'(1);
    localparam logic [ACT_TW-1:0]    T_RCD_L   = ACT_TW'(T_RCD);
    localparam logic [ACT_TW-1:0]    T_RAS_L   = ACT_TW'(T_RAS);
    localparam logic [PRE_TW-1:0]    PRE_SAT   = PRE_TW'(T_RP);
    localparam logic [PRE_TW-1:0]    PRE_ONE   = PRE_TW'(1);
    localparam logic [PRE_TW-1:0]    T_RP_L    = PRE_TW'(T_RP);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [BANK_IDX_W-1:0] cmd_idx;
    logic                  is_act;
    logic                  is_pre;
    logic                  is_rd;

    assign cmd_idx = {cmd_bg, cmd_bank};
    assign is_act  = (cmd_type == CMD_ACT);
    assign is_pre  = (cmd_type == CMD_PRE);
    assign is_rd   = (cmd_type == CMD_RD);

    // ------------------------------------------------------------------
    // Per-bank shadow state: open flag, open row, cycles since ACT / PRE.
    // Each timer is loaded with 1 on its command edge. The value seen at a
    // later edge therefore equals the distance k to that command.
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0] open_vec;
    logic [ROW_WIDTH-1:0] open_row  [NUM_BANKS];
    logic [ACT_TW-1:0]    act_timer [NUM_BANKS];
    logic [PRE_TW-1:0]    pre_timer [NUM_BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic                 bank_hit;
            logic                 open_reg;
            logic [ROW_WIDTH-1:0] row_reg;
            logic [ACT_TW-1:0]    act_t_reg;
            logic [PRE_TW-1:0]    pre_t_reg;

            assign bank_hit = (cmd_idx == BANK_IDX_W'(gi));

            // Track open row and timers. An erroneous ACT still reopens the bank and restarts its timer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    open_reg  <= 1'b0;
                    row_reg   <= '0;
                    act_t_reg <= ACT_SAT;
                    pre_t_reg <= PRE_SAT;
                end else if (clear) begin
                    open_reg  <= 1'b0;
                    row_reg   <= '0;
                    act_t_reg <= ACT_SAT;
                    pre_t_reg <= PRE_SAT;
                end else begin
                    if (is_act && bank_hit) begin
                        open_reg  <= 1'b1;
                        row_reg   <= cmd_row;
                        act_t_reg <= ACT_ONE;
                    end else if (act_t_reg != ACT_SAT) begin
                        act_t_reg <= act_t_reg + ACT_ONE;
                    end

                    if (is_pre && bank_hit) begin
                        open_reg  <= 1'b0;
                        pre_t_reg <= PRE_ONE;
                    end else if (pre_t_reg != PRE_SAT) begin
                        pre_t_reg <= pre_t_reg + PRE_ONE;
                    end
                end
            end

            assign open_vec[gi]  = open_reg;
            assign open_row[gi]  = row_reg;
            assign act_timer[gi] = act_t_reg;
            assign pre_timer[gi] = pre_t_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request log table. Valid bits are flops so that reset and clear can
    // invalidate every entry at once. Bank and row live in a plain array
    // with a combinational read. An RD therefore sees the entry written
    // before its edge, and never one written at the same edge.
    // ------------------------------------------------------------------
    logic [LOG_DEPTH-1:0]  log_valid_reg;
    logic [BANK_IDX_W-1:0] log_bank_mem [LOG_DEPTH];
    logic [ROW_WIDTH-1:0]  log_row_mem  [LOG_DEPTH];

    // Valid bits: set on log write, dropped on reset/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid_reg <= '0;
        end else if (clear) begin
            log_valid_reg <= '0;
        end else if (log_valid) begin
            log_valid_reg[log_id] <= 1'b1;
        end
    end

    // Entry payload. It needs no reset because the valid bit guards it.
    always_ff @(posedge clk) begin
        if (log_valid && !clear) begin
            log_bank_mem[log_id] <= {log_bg, log_bank};
            log_row_mem[log_id]  <= log_row;
        end
    end

    // ------------------------------------------------------------------
    // Rule evaluation for the command at this edge
    // ------------------------------------------------------------------
    logic                  sel_open;
    logic [ROW_WIDTH-1:0]  sel_row;
    logic [ACT_TW-1:0]     sel_act_t;
    logic [PRE_TW-1:0]     sel_pre_t;
    logic                  lk_valid;
    logic [BANK_IDX_W-1:0] lk_bank;
    logic [ROW_WIDTH-1:0]  lk_row;

    assign sel_open  = open_vec[cmd_idx];
    assign sel_row   = open_row[cmd_idx];
    assign sel_act_t = act_timer[cmd_idx];
    assign sel_pre_t = pre_timer[cmd_idx];
    assign lk_valid  = log_valid_reg[cmd_req_id];
    assign lk_bank   = log_bank_mem[cmd_req_id];
    assign lk_row    = log_row_mem[cmd_req_id];

    logic [6:0]            raised;
    logic [2:0]            err_code_next;
    logic [BANK_IDX_W-1:0] err_bank_next;

    // Raise every applicable rule. Bit i corresponds to error code i+1.
    always_comb begin
        raised    = '0;
        raised[0] = is_act && sel_open;
        raised[1] = is_rd && !sel_open;
        raised[2] = is_rd && sel_open && lk_valid &&
                    ((lk_bank != cmd_idx) || (lk_row != sel_row));
        raised[3] = is_rd && (sel_act_t < T_RCD_L);
        raised[4] = is_act && (sel_pre_t < T_RP_L);
        // A PRE to a closed bank is legal, so tRAS applies only to an open bank.
        raised[5] = is_pre && sel_open && (sel_act_t < T_RAS_L);
        raised[6] = is_rd && !lk_valid;
    end

    // Lowest raised code wins. Code and bank stay 0 when nothing is raised.
    always_comb begin
        err_code_next = '0;
        err_bank_next = '0;
        for (int i = 6; i >= 0; i--) begin
            if (raised[i]) begin
                err_code_next = 3'(i + 1);
            end
        end
        if (raised != '0) begin
            err_bank_next = cmd_idx;
        end
    end

    // ------------------------------------------------------------------
    // Registered error report, sticky flags and command statistics
    // ------------------------------------------------------------------
    logic                  err_valid_reg;
    logic [2:0]            err_code_reg;
    logic [BANK_IDX_W-1:0] err_bank_reg;
    logic [6:0]            err_flags_reg;
    logic [CNT_WIDTH-1:0]  act_cnt_reg;
    logic [CNT_WIDTH-1:0]  pre_cnt_reg;
    logic [CNT_WIDTH-1:0]  rd_cnt_reg;

    // Register the error pulse and accumulate sticky flags. Clear suppresses checking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_reg <= 1'b0;
            err_code_reg  <= '0;
            err_bank_reg  <= '0;
            err_flags_reg <= '0;
        end else if (clear) begin
            err_valid_reg <= 1'b0;
            err_code_reg  <= '0;
            err_bank_reg  <= '0;
            err_flags_reg <= '0;
        end else begin
            err_valid_reg <= (raised != '0);
            err_code_reg  <= err_code_next;
            err_bank_reg  <= err_bank_next;
            err_flags_reg <= err_flags_reg | raised;
        end
    end

    // Saturating counts of ACT/PRE/RD. Erroneous commands are counted too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt_reg <= '0;
            pre_cnt_reg <= '0;
            rd_cnt_reg  <= '0;
        end else if (clear) begin
            act_cnt_reg <= '0;
            pre_cnt_reg <= '0;
            rd_cnt_reg  <= '0;
        end else begin
            if (is_act && (act_cnt_reg != CNT_MAX)) begin
                act_cnt_reg <= act_cnt_reg + CNT_ONE;
            end
            if (is_pre && (pre_cnt_reg != CNT_MAX)) begin
                pre_cnt_reg <= pre_cnt_reg + CNT_ONE;
            end
            if (is_rd && (rd_cnt_reg != CNT_MAX)) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_ONE;
            end
        end
    end

    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;
    assign err_bank  = err_bank_reg;
    assign err_flags = err_flags_reg;
    assign open_mask = open_vec;
    assign act_count = act_cnt_reg;
    assign pre_count = pre_cnt_reg;
    assign rd_count  = rd_cnt_reg;

endmodule

// File: tb/tb_dram_cmd_checker.sv
// Directed testbench for dram_cmd_checker. It uses CNT_WIDTH=4 so that
// counter saturation can be reached quickly. All other parameters keep
// their default values.
module tb_dram_cmd_checker;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        log_valid;
    logic [5:0]  log_id;
    logic [1:0]  log_bg;
    logic [1:0]  log_bank;
    logic [15:0] log_row;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [5:0]  cmd_req_id;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [3:0]  err_bank;
    logic [6:0]  err_flags;
    logic [15:0] open_mask;
    logic [3:0]  act_count;
    logic [3:0]  pre_count;
    logic [3:0]  rd_count;

    int checks   = 0;
    int failures = 0;

    dram_cmd_checker #(
        .CNT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .log_valid  (log_valid),
        .log_id     (log_id),
        .log_bg     (log_bg),
        .log_bank   (log_bank),
        .log_row    (log_row),
        .cmd_type   (cmd_type),
        .cmd_bg     (cmd_bg),
        .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),
        .cmd_req_id (cmd_req_id),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_bank   (err_bank),
        .err_flags  (err_flags),
        .open_mask  (open_mask),
        .act_count  (act_count),
        .pre_count  (pre_count),
        .rd_count   (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic log_write(input logic [5:0] id, input logic [3:0] b, input logic [15:0] row);
        log_valid = 1'b1;
        log_id = id;
        {log_bg, log_bank} = b;
        log_row = row;
        step();
        log_valid = 1'b0;
        $display("log id=%0d bank=%0d row=%h", id, b, row);
    endtask

    // Present one command for one edge, then report the registered result.
    task automatic issue(input logic [2:0] t, input logic [3:0] b, input logic [15:0] row,
                         input logic [5:0] id);
        cmd_type = t;
        {cmd_bg, cmd_bank} = b;
        cmd_row = row;
        cmd_req_id = id;
        step();
        cmd_type = C_NOP;
        $display("cmd type=%0d bank=%0d row=%h id=%0d -> err_valid=%0b code=%0d ebank=%0d flags=%b",
                 t, b, row, id, err_valid, err_code, err_bank, err_flags);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({err_valid, err_code, err_bank, err_flags} !== 15'd0) begin
            failures++;
            $display("FAIL reset_err got valid=%0b code=%0d bank=%0d flags=%b exp all 0",
                     err_valid, err_code, err_bank, err_flags);
        end
        checks++;
        if ({open_mask, act_count, pre_count, rd_count} !== 28'd0) begin
            failures++;
            $display("FAIL reset_state got mask=%h act=%0d pre=%0d rd=%0d exp all 0",
                     open_mask, act_count, pre_count, rd_count);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_row_hits();
        do_clear();
        log_write(6'd0, 4'd0, 16'h0200);
        log_write(6'd1, 4'd0, 16'h0200);
        log_write(6'd2, 4'd0, 16'h0200);
        issue(C_ACT, 4'd0, 16'h0200, 6'd0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            issue(C_RD, 4'd0, 16'h0, 6'(i));
            checks++;
            if (err_valid !== 1'b0 || err_code !== 3'd0) begin
                failures++;
                $display("FAIL hit_rd%0d got valid=%0b code=%0d exp valid=0 code=0", i, err_valid, err_code);
            end
        end
        checks++;
        if (rd_count !== 4'd3 || act_count !== 4'd1 || open_mask !== 16'h0001) begin
            failures++;
            $display("FAIL hit_stats got rd=%0d act=%0d mask=%h exp rd=3 act=1 mask=0001",
                     rd_count, act_count, open_mask);
        end
        issue(C_WR, 4'd0, 16'h0, 6'd0);
        issue(C_REF, 4'd2, 16'h0, 6'd0);
        checks++;
        if (rd_count !== 4'd3 || act_count !== 4'd1 || pre_count !== 4'd0 || err_valid !== 1'b0) begin
            failures++;
            $display("FAIL ignored_cmds got rd=%0d act=%0d pre=%0d valid=%0b exp rd=3 act=1 pre=0 valid=0",
                     rd_count, act_count, pre_count, err_valid);
        end
    endtask

    task automatic test_row_conflict();
        do_clear();
        issue(C_ACT, 4'd0, 16'h000A, 6'd0);
        idle(7);
        issue(C_PRE, 4'd0, 16'h0, 6'd0);
        checks++;
        if (err_valid !== 1'b0 || open_mask !== 16'h0000) begin
            failures++;
            $display("FAIL pre_at_tras got valid=%0b mask=%h exp valid=0 mask=0000", err_valid, open_mask);
        end
        idle(3);
        issue(C_ACT, 4'd0, 16'h000B, 6'd0);
        checks++;
        if (err_valid !== 1'b0 || open_mask !== 16'h0001) begin
            failures++;
            $display("FAIL act_at_trp got valid=%0b mask=%h exp valid=0 mask=0001", err_valid, open_mask);
        end
        idle(7);
        issue(C_ACT, 4'd0, 16'h000B, 6'd0);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd1 || err_bank !== 4'd0 || err_flags !== 7'b0000001) begin
            failures++;
            $display("FAIL act_open got valid=%0b code=%0d bank=%0d flags=%b exp 1/1/0/0000001",
                     err_valid, err_code, err_bank, err_flags);
        end
        step();
        checks++;
        if (err_valid !== 1'b0 || err_code !== 3'd0 || err_flags !== 7'b0000001) begin
            failures++;
            $display("FAIL pulse_end got valid=%0b code=%0d flags=%b exp 0/0/0000001",
                     err_valid, err_code, err_flags);
        end
        checks++;
        if (act_count !== 4'd3 || pre_count !== 4'd1) begin
            failures++;
            $display("FAIL conflict_counts got act=%0d pre=%0d exp act=3 pre=1", act_count, pre_count);
        end
    endtask

    task automatic test_timing();
        log_write(6'd6, 4'd1, 16'h0011);
        issue(C_ACT, 4'd1, 16'h0011, 6'd0);
        idle(2);
        issue(C_RD, 4'd1, 16'h0, 6'd6);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd4 || err_bank !== 4'd1) begin
            failures++;
            $display("FAIL trcd got valid=%0b code=%0d bank=%0d exp 1/4/1", err_valid, err_code, err_bank);
        end
        idle(3);
        issue(C_PRE, 4'd1, 16'h0, 6'd0);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd6 || err_bank !== 4'd1) begin
            failures++;
            $display("FAIL tras got valid=%0b code=%0d bank=%0d exp 1/6/1", err_valid, err_code, err_bank);
        end
        idle(1);
        issue(C_ACT, 4'd1, 16'h0011, 6'd0);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd5 || err_bank !== 4'd1) begin
            failures++;
            $display("FAIL trp got valid=%0b code=%0d bank=%0d exp 1/5/1", err_valid, err_code, err_bank);
        end
        checks++;
        if (err_flags !== 7'b0111001) begin
            failures++;
            $display("FAIL timing_flags got %b exp 0111001", err_flags);
        end
    endtask

    task automatic test_read_checks();
        log_write(6'd4, 4'd0, 16'h000B);
        issue(C_RD, 4'd2, 16'h0, 6'd4);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd2 || err_bank !== 4'd2) begin
            failures++;
            $display("FAIL rd_closed got valid=%0b code=%0d bank=%0d exp 1/2/2", err_valid, err_code, err_bank);
        end
        log_write(6'd5, 4'd0, 16'h000C);
        issue(C_RD, 4'd0, 16'h0, 6'd5);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd3 || err_bank !== 4'd0) begin
            failures++;
            $display("FAIL rd_row_mismatch got valid=%0b code=%0d bank=%0d exp 1/3/0", err_valid, err_code, err_bank);
        end
        issue(C_RD, 4'd0, 16'h0, 6'd9);
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd7) begin
            failures++;
            $display("FAIL rd_unlogged got valid=%0b code=%0d exp 1/7", err_valid, err_code);
        end
        // Log write and RD of the same ID at one edge: RD sees the old (invalid) entry.
        log_valid = 1'b1;
        log_id = 6'd3;
        {log_bg, log_bank} = 4'd0;
        log_row = 16'h000B;
        issue(C_RD, 4'd0, 16'h0, 6'd3);
        log_valid = 1'b0;
        checks++;
        if (err_valid !== 1'b1 || err_code !== 3'd7) begin
            failures++;
            $display("FAIL rd_same_edge_log got valid=%0b code=%0d exp 1/7", err_valid, err_code);
        end
        issue(C_RD, 4'd0, 16'h0, 6'd3);
        checks++;
        if (err_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_log got valid=%0b code=%0d exp valid=0", err_valid, err_code);
        end
        checks++;
        if (err_flags !== 7'b1111111) begin
            failures++;
            $display("FAIL read_flags got %b exp 1111111", err_flags);
        end
    endtask

    task automatic test_saturation_clear();
        do_clear();
        log_write(6'd0, 4'd0, 16'h0020);
        issue(C_ACT, 4'd0, 16'h0020, 6'd0);
        idle(3);
        for (int i = 0; i < 17; i++) begin
            issue(C_RD, 4'd0, 16'h0, 6'd0);
            if (i == 14) begin
                checks++;
                if (rd_count !== 4'd15) begin
                    failures++;
                    $display("FAIL rd_count_at_15 got %0d exp 15", rd_count);
                end
            end
        end
        checks++;
        if (rd_count !== 4'd15 || act_count !== 4'd1 || err_flags !== 7'd0) begin
            failures++;
            $display("FAIL rd_saturate got rd=%0d act=%0d flags=%b exp rd=15 act=1 flags=0",
                     rd_count, act_count, err_flags);
        end
        clear = 1'b1;
        issue(C_ACT, 4'd0, 16'h0020, 6'd0);
        clear = 1'b0;
        checks++;
        if ({err_valid, err_code, err_bank, err_flags, open_mask, act_count, pre_count, rd_count} !== 43'd0) begin
            failures++;
            $display("FAIL clear_with_act got valid=%0b code=%0d mask=%h act=%0d pre=%0d rd=%0d flags=%b exp all 0",
                     err_valid, err_code, open_mask, act_count, pre_count, rd_count, err_flags);
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        issue(C_ACT, 4'd0, 16'h0001, 6'd0);
        issue(C_ACT, 4'd3, 16'h0002, 6'd0);
        issue(C_ACT, 4'd0, 16'h0001, 6'd0);
        checks++;
        if (open_mask !== 16'h0009 || err_flags !== 7'b0000001 || act_count !== 4'd3) begin
            failures++;
            $display("FAIL pre_reset_state got mask=%h flags=%b act=%0d exp mask=0009 flags=0000001 act=3",
                     open_mask, err_flags, act_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({open_mask, act_count, pre_count, rd_count, err_flags, err_valid} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset got mask=%h act=%0d pre=%0d rd=%0d flags=%b valid=%0b exp all 0",
                     open_mask, act_count, pre_count, rd_count, err_flags, err_valid);
        end
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (open_mask !== 16'h0000 || act_count !== 4'd0) begin
            failures++;
            $display("FAIL after_reset got mask=%h act=%0d exp mask=0000 act=0", open_mask, act_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        log_valid = 1'b0;
        log_id = '0;
        log_bg = '0;
        log_bank = '0;
        log_row = '0;
        cmd_type = C_NOP;
        cmd_bg = '0;
        cmd_bank = '0;
        cmd_row = '0;
        cmd_req_id = '0;

        test_reset();
        test_row_hits();
        test_row_conflict();
        test_timing();
        test_read_checks();
        test_saturation_clear();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_cmd_checker.md
# dram_cmd_checker

Synthesizable, parametrised DRAM command-stream protocol checker attached to the scheduler's command output (or its schedule read-back path). Keeps a shadow open-row table per bank, a logged-request row table indexed by request ID, and per-bank timing counters. Flags illegal ACT, PRE and RD sequences and timing violations as registered error pulses plus sticky flags, and keeps saturating command statistics.

## Interface
- NUM_BANKS, 16, bank count; bank index = {bg, bank}; must equal 2^(BG_WIDTH+BANK_WIDTH)
- BG_WIDTH, 2, bank-group field width
- BANK_WIDTH, 2, bank field width
- ROW_WIDTH, 16, row address width
- REQ_ID_WIDTH, 6, request ID width; log table depth = 2^REQ_ID_WIDTH
- CNT_WIDTH, 16, statistics counter width
- T_RCD, 4, minimum cycles from ACT to RD on the same bank (≥1)
- T_RP, 4, minimum cycles from PRE to ACT on the same bank (≥1)
- T_RAS, 8, minimum cycles from ACT to PRE on the same bank (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all state, counters and flags
- log_valid  in  1  record one request into the log table
- log_id  in  REQ_ID_WIDTH  request ID to record
- log_bg / log_bank  in  BG_WIDTH / BANK_WIDTH  bank of the logged request
- log_row  in  ROW_WIDTH  row of the logged request
- cmd_type  in  3  CMD_* encoding from dram_scheduler_types.vh; 0 = no command
- cmd_bg / cmd_bank  in  BG_WIDTH / BANK_WIDTH  target bank
- cmd_row  in  ROW_WIDTH  row; used by ACT only
- cmd_req_id  in  REQ_ID_WIDTH  request ID; used by RD only
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  highest-priority error of the flagged command
- err_bank  out  BG_WIDTH+BANK_WIDTH  bank index of the flagged command
- err_flags  out  7  sticky; bit (code-1) is set for each code ever raised
- open_mask  out  NUM_BANKS  bit i = 1 while bank i holds an open row
- act_count / pre_count / rd_count  out  CNT_WIDTH  saturating command counts

## Operation
- Reset state: all banks closed; log table entries invalid; timers saturated (any command is timing-legal). All outputs are 0.
- Command types other than ACT, PRE and RD, including 0, are ignored.
- Per-cycle checks. Codes are listed in priority order; the lowest code wins on err_code, and all raised codes OR into err_flags:
  - 1 ACT_OPEN: ACT to a bank that is open.
  - 2 RD_CLOSED: RD to a bank that is closed.
  - 3 RD_ROW_MISMATCH: RD whose logged entry is valid and whose logged bank or row differs from the bank's open row.
  - 4 TRCD: RD issued k cycles after the last ACT to the same bank, with k < T_RCD.
  - 5 TRP: ACT issued k cycles after the last PRE to the same bank, with k < T_RP.
  - 6 TRAS: PRE issued k cycles after the last ACT to the same bank, with k < T_RAS.
  - 7 RD_UNLOGGED: RD whose cmd_req_id has no valid log entry.
- A PRE to a closed bank is legal: no error, pre_count still increments.
- Erroneous commands still update state:
  - ACT to an open bank overwrites the open row and restarts that bank's ACT timer.
  - RD changes no bank state.
- Per-bank timers count cycles since the last ACT and since the last PRE. Each saturates at max(T_RCD, T_RAS) or T_RP respectively. Width is the clog2 of that maximum plus 1.
- A log write to an ID that is already valid overwrites the entry.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.

## Timing
- err_valid, err_code and err_bank are registered: a command sampled at edge n produces its error pulse in the cycle after edge n. err_code and err_bank are 0 whenever err_valid is 0.
- open_mask, the counters and err_flags also update at edge n.
- Back-to-back commands to the same bank: the command at edge n+1 is checked against the state written at edge n.
- A log write at edge n is visible to an RD at edge n+1 or later, not at edge n. An RD at the same edge sees the old entry.
- clear has priority over cmd_type and log_valid in the same cycle. Commands in that cycle are neither checked nor counted. The cycle after clear matches the reset state.
- rst_n asserted mid-stream forces the reset state immediately, without waiting for clk.

## Test plan
- Row hits: log IDs 0-2 on bank 0 row 0x200; ACT bank 0 row 0x200 at t=0; RD IDs 0, 1, 2 at t=4, 5, 6 (T_RCD=4) -> no err_valid; rd_count=3, act_count=1, open_mask=0x0001.
- Row conflict: ACT b0 row 0x0A at t=0; PRE at t=8; ACT row 0x0B at t=12 -> clean. Then ACT b0 at t=20 without a PRE -> err_valid at t=21 with code 1, err_bank 0, err_flags=0b0000001.
- Timing: ACT b1 at t=0, RD at t=3 -> code 4. Then PRE at t=7 -> code 6. Then ACT at t=9 -> code 5; code 1 is not raised because the bank was closed by the PRE at t=7.
- Read checks: RD to closed bank 2 -> code 2. RD to open bank 0 row 0x0B with log ID 5 = row 0x0C -> code 3. RD with unlogged ID 9 -> code 7. RD with cmd_req_id=3 and log_valid for ID 3 at the same edge -> code 7.
- Saturation and clear (CNT_WIDTH=4): 17 legal RDs -> rd_count=15. Then clear together with an ACT -> all outputs 0 next cycle and act_count stays 0.
- Reset mid-operation: banks 0 and 3 open with err_flags nonzero; drop rst_n between clock edges -> open_mask, the counters and err_flags are 0 before the next edge.
